gobang_key_ctrl: RTL
====================

Name: gobang_key_ctrl

Overview:
- Controller that sequences the matrix-keyboard front end for a player's move on the Gobang board.
- Gates the keyboard scanner enable and consumes key_code/key_trick events.
- Moves a board cursor and runs an arm/confirm sequence.
- Offers the chosen (x,y) move to the game logic over a valid/ready handshake.
- Sits between the matrix keyboard block and the game FSM / display.

Parameters:
- BOARD_SIZE, 15, board dimension; cursor range 0..BOARD_SIZE-1 (max 16).
- WRAP, 0, 1 = cursor wraps at edges; 0 = cursor saturates at edges.
- LOCKOUT_CYC, 2_000_000, cycles after an accepted key during which further key_trick pulses are ignored (20 ms at 100 MHz).
- ARM_TIMEOUT, 300_000_000, cycles in ARM with no key before falling back to NAV (3 s).

Ports:
- clk_100M  in  1  system clock, 100 MHz.
- rst_p  in  1  synchronous reset, active-high.
- player_en  in  1  high while it is this player's turn.
- key_code  in  4  encoded key from the keyboard block; valid when key_trick=1.
- key_trick  in  1  single-cycle pulse per key press.
- kb_en  out  1  enable to the keyboard block.
- cursor_x  out  4  cursor column.
- cursor_y  out  4  cursor row.
- armed  out  1  high in ARM state (display highlights cursor).
- move_valid  out  1  move offer to the game logic.
- move_x  out  4  offered column; stable while move_valid=1.
- move_y  out  4  offered row; stable while move_valid=1.
- move_ready  in  1  game logic accepts the move.
- move_done  out  1  one-cycle pulse on handshake completion.

Behaviour:
- Reset, sampled on the rising edge when rst_p=1, overrides everything:
  - state=IDLE.
  - cursor_x = cursor_y = BOARD_SIZE/2, i.e. 7 for the default.
  - kb_en, armed, move_valid, move_done = 0; move_x = move_y = 0.
  - Lockout and timeout counters = 0.
  - Applies mid-handshake too: move_valid drops with no move_done.
- kb_en = 1 when state is NAV or ARM; registered, so it follows the state with no extra delay.
- Accepted key: key_trick=1, lockout counter = 0, and state is NAV or ARM.
  - Acceptance loads the lockout counter with LOCKOUT_CYC-1; the counter decrements to 0.
  - Pulses arriving during lockout are dropped entirely.
- Key map:
  - 2 = up (y-1), 8 = down (y+1), 4 = left (x-1), 6 = right (x+1).
  - 5 = confirm, C = cancel, F = home (cursor to centre).
  - All other codes are accepted (lockout starts) but have no effect.
- Edge behaviour:
  - WRAP=0: saturate at 0 and BOARD_SIZE-1.
  - WRAP=1: 0-1 → BOARD_SIZE-1, and BOARD_SIZE-1+1 → 0.
- Cursor outputs update in the cycle after the accepted pulse (1-cycle latency).
- States:
  - IDLE:
    - player_en=1 → NAV.
    - Cursor retained.
  - NAV:
    - Direction and home keys move the cursor.
    - Confirm → ARM; timeout counter cleared.
    - Cancel: no effect.
    - player_en=0 → IDLE.
  - ARM:
    - armed=1; cursor frozen; timeout counter increments each cycle.
    - Confirm → OFFER: move_x/move_y ← cursor, move_valid=1 next cycle.
    - Cancel or any direction key → NAV; the direction is not applied.
    - Counter reaching ARM_TIMEOUT-1 → NAV.
    - player_en=0 → IDLE.
  - OFFER:
    - move_valid=1; move_x/move_y held; keys ignored; kb_en=0.
    - move_ready=1 on a cycle with move_valid=1 → handshake completes:
      - next cycle: move_valid=0, move_done=1 for one cycle;
      - state → NAV if player_en=1, else IDLE.
    - player_en falling during OFFER does not withdraw the offer; the handshake must complete first.
    - move_ready while not in OFFER is ignored.
- Simultaneous events:
  - key_trick coinciding with player_en falling: player_en wins; the key is ignored.
  - ARM timeout coinciding with an accepted key: the key wins.

Test Plan:
- Reset, then player_en=1 → cycle after: kb_en=1, cursor=(7,7), move_valid=0; 8 cycles of key_trick with no key_code change produce exactly one accepted key.
- WRAP=0: seven "4" presses spaced > LOCKOUT_CYC → cursor_x=0; an eighth press leaves cursor_x=0. WRAP=1: eighth press gives cursor_x=14. Key "F" returns the cursor to (7,7).
- "6" press followed by a second "6" pulse 100 cycles later (LOCKOUT_CYC=1000 in the bench) → cursor_x=8 only.
- Cursor (3,9): "5", "5" → move_valid=1, move_x=3, move_y=9. Hold move_ready=0 for 50 cycles → outputs stable. move_ready=1 → next cycle move_valid=0, move_done pulses once, state NAV.
- "5" then no keys with ARM_TIMEOUT=100 → armed=1 for exactly 100 cycles, then armed=0. Separately, "5" then "C" → armed=0 and cursor unchanged.
- In OFFER, drop player_en → move_valid stays 1 until move_ready, then state IDLE, kb_en=0. rst_p=1 during OFFER → move_valid=0 next cycle and move_done never pulses.

Source files
------------

// File: rtl/gobang_key_ctrl.sv
// Move-entry controller for one Gobang player: gates the keyboard scanner,
// steers a board cursor, runs an arm/confirm sequence and offers the move.
module gobang_key_ctrl #(
  parameter int BOARD_SIZE  = 15,
  parameter int WRAP        = 0,
  parameter int LOCKOUT_CYC = 2_000_000,
  parameter int ARM_TIMEOUT = 300_000_000
) (
  input  logic       clk_100M,
  input  logic       rst_p,
  input  logic       player_en,
  input  logic [3:0] key_code,
  input  logic       key_trick,
  output logic       kb_en,
  output logic [3:0] cursor_x,
  output logic [3:0] cursor_y,
  output logic       armed,
  output logic       move_valid,
  output logic [3:0] move_x,
  output logic [3:0] move_y,
  input  logic       move_ready,
  output logic       move_done
);

  localparam int LW = (LOCKOUT_CYC > 1) ? $clog2(LOCKOUT_CYC + 1) : 1;
  localparam int TW = (ARM_TIMEOUT > 1) ? $clog2(ARM_TIMEOUT + 1) : 1;

  localparam logic [3:0] POS_MAX    = 4'(BOARD_SIZE - 1);
  localparam logic [3:0] POS_CENTRE = 4'(BOARD_SIZE / 2);

  localparam logic [3:0] K_UP     = 4'h2;
  localparam logic [3:0] K_DOWN   = 4'h8;
  localparam logic [3:0] K_LEFT   = 4'h4;
  localparam logic [3:0] K_RIGHT  = 4'h6;
  localparam logic [3:0] K_OK     = 4'h5;
  localparam logic [3:0] K_CANCEL = 4'hC;
  localparam logic [3:0] K_HOME   = 4'hF;

  typedef enum logic [1:0] {S_IDLE, S_NAV, S_ARM, S_OFFER} state_t;

  state_t          state_reg, state_next;
  logic [LW-1:0]   lock_reg, lock_next;
  logic [TW-1:0]   tmo_reg, tmo_next;
  logic [3:0]      cx_next, cy_next, mx_next, my_next;
  logic            kb_en_next, armed_next, move_valid_next, move_done_next;
  logic            accept, is_dir;

  function automatic logic [3:0] pos_dec(input logic [3:0] v);
    if (v == 4'd0) return (WRAP != 0) ? POS_MAX : 4'd0;
    return v - 4'd1;
  endfunction

  function automatic logic [3:0] pos_inc(input logic [3:0] v);
    if (v >= POS_MAX) return (WRAP != 0) ? 4'd0 : POS_MAX;
    return v + 4'd1;
  endfunction

  // A key counts only while the scanner is live, the lockout has expired
  // and the turn is still ours (player_en dropping beats a coincident key).
  assign accept = key_trick && (lock_reg == '0) && player_en &&
                  ((state_reg == S_NAV) || (state_reg == S_ARM));
  assign is_dir = (key_code == K_UP) || (key_code == K_DOWN) ||
                  (key_code == K_LEFT) || (key_code == K_RIGHT);

  always_ff @(posedge clk_100M) begin
    if (rst_p) begin
      state_reg  <= S_IDLE;
      lock_reg   <= '0;
      tmo_reg    <= '0;
      cursor_x   <= POS_CENTRE;
      cursor_y   <= POS_CENTRE;
      move_x     <= 4'd0;
      move_y     <= 4'd0;
      kb_en      <= 1'b0;
      armed      <= 1'b0;
      move_valid <= 1'b0;
      move_done  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      lock_reg   <= lock_next;
      tmo_reg    <= tmo_next;
      cursor_x   <= cx_next;
      cursor_y   <= cy_next;
      move_x     <= mx_next;
      move_y     <= my_next;
      kb_en      <= kb_en_next;
      armed      <= armed_next;
      move_valid <= move_valid_next;
      move_done  <= move_done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: if (player_en) state_next = S_NAV;
      S_NAV: begin
        if (!player_en)                     state_next = S_IDLE;
        else if (accept && key_code == K_OK) state_next = S_ARM;
      end
      S_ARM: begin
        if (!player_en) state_next = S_IDLE;
        else if (accept) begin
          if (key_code == K_OK)                     state_next = S_OFFER;
          else if (key_code == K_CANCEL || is_dir)  state_next = S_NAV;
        end else if (tmo_reg == TW'(ARM_TIMEOUT - 1)) state_next = S_NAV;
      end
      S_OFFER: if (move_ready) state_next = player_en ? S_NAV : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so they line up
  // with the state register rather than trailing it by a cycle.
  always_comb begin
    kb_en_next      = (state_next == S_NAV) || (state_next == S_ARM);
    armed_next      = (state_next == S_ARM);
    move_valid_next = (state_next == S_OFFER);
    move_done_next  = (state_reg == S_OFFER) && move_ready;

    lock_next = lock_reg;
    if (accept)               lock_next = LW'(LOCKOUT_CYC - 1);
    else if (lock_reg != '0)  lock_next = lock_reg - LW'(1);

    tmo_next = tmo_reg;
    if (state_reg == S_NAV && state_next == S_ARM)      tmo_next = '0;
    else if (state_reg == S_ARM && state_next == S_ARM) tmo_next = accept ? '0 : tmo_reg + TW'(1);

    cx_next = cursor_x;
    cy_next = cursor_y;
    if (state_reg == S_NAV && accept) begin
      case (key_code)
        K_UP:    cy_next = pos_dec(cursor_y);
        K_DOWN:  cy_next = pos_inc(cursor_y);
        K_LEFT:  cx_next = pos_dec(cursor_x);
        K_RIGHT: cx_next = pos_inc(cursor_x);
        K_HOME: begin
          cx_next = POS_CENTRE;
          cy_next = POS_CENTRE;
        end
        default: ;
      endcase
    end

    mx_next = move_x;
    my_next = move_y;
    if (state_reg == S_ARM && state_next == S_OFFER) begin
      mx_next = cursor_x;
      my_next = cursor_y;
    end
  end

endmodule
